// File: rtl/spi_rx_stream.sv
// spi_rx_stream: clk-oversampled SPI slave receiver (all four modes) with a one-word valid/ready output buffer.
// Optional: define SPI_RX_FRAME_ADDR_RST_EN to restart the write address at 0 on every CS frame.

module spi_rx_stream #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768,
  parameter int CNT_W  = 16,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0,
  localparam int BC_W  = $clog2(WORD_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic [WORD_W-1:0] word_out,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  bytes_received,
  output logic [BC_W-1:0]   bit_count,
  output logic              overflow,
  output logic              frame_error,
  output logic              busy
);

  localparam logic            SCLK_IDLE   = (CPOL != 0);
  localparam logic            SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WORD_BYTES = CNT_W'(WORD_W / 8);

`ifdef SPI_RX_FRAME_ADDR_RST_EN
  localparam logic FRAME_ADDR_RST = 1'b1;
`else
  localparam logic FRAME_ADDR_RST = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Synchroniser chains; bit order is {cs_n, mosi, sclk}, reset to the bus idle levels.
  localparam logic [2:0] SYNC_IDLE = {1'b1, 1'b0, SCLK_IDLE};

  logic [2:0] sync_in;
  logic [2:0] sync_out;
  logic       sclk_prev_reg;
  logic       sclk_sync;
  logic       mosi_sync;
  logic       cs_sync;
  logic       sample_edge;

  assign sync_in = {spi_cs_n, spi_mosi, spi_sclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_reg <= SYNC_IDLE[gi];
          sync_reg <= SYNC_IDLE[gi];
        end else begin
          meta_reg <= sync_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_out[gi] = sync_reg;
    end
  endgenerate

  assign cs_sync   = sync_out[2];
  assign mosi_sync = sync_out[1];
  assign sclk_sync = sync_out[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_reg <= SCLK_IDLE;
    end else begin
      sclk_prev_reg <= sclk_sync;
    end
  end

  assign sample_edge = SAMPLE_RISE ? (sclk_sync & ~sclk_prev_reg)
                                   : (~sclk_sync & sclk_prev_reg);

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   shift_reg, shift_next;
  logic [BC_W-1:0]     bit_count_reg, bit_count_next;
  logic [WORD_W-1:0]   word_reg, word_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   addr_cnt_reg, addr_cnt_next;
  logic                valid_reg, valid_next;
  logic [CNT_W-1:0]    bytes_reg, bytes_next;
  logic                overflow_reg, overflow_next;
  logic                frame_error_reg, frame_error_next;

  logic                frame_start;
  logic                frame_abort;
  logic                word_complete;
  logic                load;
  logic [ADDR_W-1:0]   addr_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame sequencing: CS release always wins over a coincident sample edge.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_count_next = bit_count_reg;
    frame_start    = 1'b0;
    frame_abort    = 1'b0;
    word_complete  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!cs_sync) begin
          state_next     = SHIFT;
          bit_count_next = '0;
          shift_next     = '0;
          frame_start    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_sync) begin
          state_next     = IDLE;
          bit_count_next = '0;
          frame_abort    = (bit_count_reg != '0);
        end else if (sample_edge) begin
          shift_next = (shift_reg << 1) | WORD_W'(mosi_sync);
          if (bit_count_reg == LAST_BIT) begin
            word_complete  = 1'b1;
            bit_count_next = '0;
          end else begin
            bit_count_next = bit_count_reg + BC_W'(1);
          end
        end
      end
      default: begin
        state_next     = IDLE;
        bit_count_next = '0;
      end
    endcase
  end

  assign addr_inc = (addr_cnt_reg == ADDR_LAST) ? '0 : addr_cnt_reg + ADDR_W'(1);

  // Output buffer: an acceptance in the same cycle frees the slot for the completing word.
  always_comb begin
    load             = word_complete & (~valid_reg | word_ready);
    word_next        = word_reg;
    addr_next        = addr_reg;
    addr_cnt_next    = addr_cnt_reg;
    bytes_next       = bytes_reg;
    valid_next       = valid_reg & ~word_ready;
    overflow_next    = overflow_reg | (word_complete & valid_reg & ~word_ready);
    frame_error_next = frame_abort;
    if (load) begin
      word_next     = shift_next;
      addr_next     = addr_cnt_reg;
      addr_cnt_next = addr_inc;
      bytes_next    = bytes_reg + WORD_BYTES;
      valid_next    = 1'b1;
    end else if (frame_start && FRAME_ADDR_RST) begin
      addr_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg       <= '0;
      bit_count_reg   <= '0;
      word_reg        <= '0;
      addr_reg        <= '0;
      addr_cnt_reg    <= '0;
      valid_reg       <= 1'b0;
      bytes_reg       <= '0;
      overflow_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      shift_reg       <= shift_next;
      bit_count_reg   <= bit_count_next;
      word_reg        <= word_next;
      addr_reg        <= addr_next;
      addr_cnt_reg    <= addr_cnt_next;
      valid_reg       <= valid_next;
      bytes_reg       <= bytes_next;
      overflow_reg    <= overflow_next;
      frame_error_reg <= frame_error_next;
    end
  end

  assign word_out       = word_reg;
  assign word_addr      = addr_reg;
  assign word_valid     = valid_reg;
  assign bytes_received = bytes_reg;
  assign bit_count      = bit_count_reg;
  assign overflow       = overflow_reg;
  assign frame_error    = frame_error_reg;
  assign busy           = (state_reg == SHIFT);

endmodule

// File: doc/spi_rx_stream.md
Name: spi_rx_stream

Overview:
- Parametrised SPI slave receiver; successor to the fixed 16-bit, SCLK-clocked receiver.
- Runs on system clock clk and oversamples SCLK, MOSI and CS_n through synchronisers. Supports all four SPI modes, any word width, CS framing and a valid/ready output with a one-word skid buffer.
- Each completed word carries a wrapping write address. A running byte count feeds the downstream sample-RAM writer.

Parameters:
- WORD_W, 16, bits per received word; multiple of 8, 8..32.
- ADDR_W, 15, width of write address.
- DEPTH, 32768, address wrap point; address runs 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- CNT_W, 16, width of byte counter.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock; f_sclk <= f_clk/4.
- reset  in  1  reset, asynchronous, active-high.
- spi_sclk  in  1  SPI clock, asynchronous to clk.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs_n  in  1  chip select, active-low.
- word_out  out  WORD_W  received word.
- word_addr  out  ADDR_W  address attached to word_out.
- word_valid  out  1  word_out/word_addr valid.
- word_ready  in  1  consumer accepts when valid && ready.
- bytes_received  out  CNT_W  total bytes captured; wraps modulo 2**CNT_W.
- bit_count  out  $clog2(WORD_W)+1  bits shifted in the current word.
- overflow  out  1  sticky; set when a completed word is dropped.
- frame_error  out  1  one-cycle pulse; CS released mid-word.
- busy  out  1  high while in SHIFT state.

Behaviour:
- Reset values (asynchronous): all outputs 0; shift register 0; state IDLE; address counter 0; synchroniser flops set to idle levels (sclk=CPOL, cs_n=1, mosi=0).
- Synchronisation: 2-FF synchronisers on sclk, mosi and cs_n, plus one extra sclk stage for edge detection.
- Sample edge: rising when CPOL==CPHA, otherwise falling. Edges are detected on synchronised signals only.
- State IDLE:
  - Waits for synchronised cs_n == 0, then enters SHIFT with bit_count=0.
  - Sample edges are ignored while cs_n is high.
- State SHIFT:
  - On each sample edge, shift the synchronised mosi in MSB first and increment bit_count.
  - When bit_count reaches WORD_W-1 and a sample edge occurs, the word completes: load the output register and reset bit_count to 0.
  - word_valid rises on the next clk cycle after the detected edge, so latency is 1 clk from edge detect.
- Word completion:
  - word_addr takes the current address counter value.
  - The address counter increments, going from DEPTH-1 to 0.
  - bytes_received increments by WORD_W/8.
- Handshake:
  - word_out and word_addr hold stable while valid && !ready.
  - word_valid drops the cycle after acceptance unless a new word completes in that same cycle.
- Overflow:
  - If a word completes while word_valid && !word_ready, the new word is dropped and overflow is set (sticky until reset).
  - A dropped word does not advance the address counter or bytes_received.
- Simultaneous accept and complete: the accept takes effect first. The new word loads, word_valid stays 1 and no overflow is raised.
- CS deassertion:
  - In SHIFT with bit_count==0: return to IDLE cleanly.
  - In SHIFT with bit_count!=0: discard the partial word, pulse frame_error for 1 cycle, clear bit_count and return to IDLE. The address counter is retained.
  - A pending valid word is unaffected by CS deassertion.
- busy = (state == SHIFT).
- Reset mid-word or mid-handshake: everything clears immediately, including any pending word; the address counter returns to 0.

Optional Feature:
- Macro SPI_RX_FRAME_ADDR_RST_EN.
- Defined: each IDLE->SHIFT transition (CS falling) resets the address counter to 0, so every frame writes from address 0. bytes_received is not reset.
- Undefined: the address counter runs continuously across frames and wraps only at DEPTH.

Test Plan:
- Mode 0, WORD_W=16, CS low, send 0xA5C3 then 0x1234, word_ready=1 -> word_out=0xA5C3/addr 0, then 0x1234/addr 1; bytes_received=4; overflow=0.
- Mode 3 (CPOL=1, CPHA=1): send 0x8001 -> word_out=0x8001, proving the sample edge. Repeat with the bench driving data on the wrong edge -> mismatch expected (checker sanity).
- word_ready=0, send 0x1111 then 0x2222 -> word_out holds 0x1111; overflow=1; bytes_received=2; next accepted word gets addr 1.
- Raise CS after 7 bits -> frame_error one-cycle pulse, no word_valid, bit_count=0. Next full word 0xBEEF gets addr unchanged from before.
- DEPTH=4, send 5 words -> addresses 0,1,2,3,0.
- Assert reset after 9 bits with a valid word pending -> all outputs 0 within the reset. A fresh word after release gets addr 0. With SPI_RX_FRAME_ADDR_RST_EN defined, a second CS frame restarts at addr 0.
